// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, register window addresses, frame constants.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 instead of 8N1).
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam logic [31:0] UART_DATA_ADDR   = 32'h0000_4000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_4004;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Decoder-side port bundle of the UART transmitter: write strobe, store data, busy, line.
interface uart_tx_if;
  import uart_pkg::*;

  logic        uart_write;
  logic [31:0] data_in;
  logic        uart_busy;
  logic        tx;

  modport master (
    output uart_write,
    output data_in,
    input  uart_busy,
    input  tx
  );

  modport slave (
    input  uart_write,
    input  data_in,
    output uart_busy,
    output tx
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntMax);

  // Held at zero while disabled so every bit period starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: one-cycle write strobe in, 8N1 serial frame out.
// Define UART_TX_PARITY_EN for an even-parity bit between data and stop (8E1).
module uart_tx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);
  import uart_pkg::*;

  // Must come out at 2 or more for the bit-period counter to work.
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BitCntW = $clog2(DATA_BITS);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 baud_en, baud_tick;
  logic                 unused_data_hi;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  assign unused_data_hi = ^bus.data_in[31:DATA_BITS];
  assign baud_en        = (state_q != StIdle);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (baud_en),
    .tick (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Writes are only seen here, so anything arriving mid-frame is dropped.
        if (bus.uart_write) begin
          state_d   = StStart;
          shift_d   = bus.data_in[DATA_BITS-1:0];
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(bus.data_in[DATA_BITS-1:0]);
`endif
        end
      end
      StStart: begin
        if (baud_tick) state_d = StData;
      end
      StData: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_tick) state_d = StStop;
      end
`endif
      StStop: begin
        if (baud_tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they land in flops with the transition.
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign bus.tx        = tx_q;
  assign bus.uart_busy = busy_q;

endmodule
